sll_seq: RTL and testbench

- Multi-cycle left shifter/rotator for the 16-bit datapath. It is the left-direction partner of the combinational right-shift stages.
- Accepts an operand and a 4-bit shift count on a start pulse, then shifts the operand left by up to 2 bits per cycle.
- Pulses done with the registered result.
- Used by the execute stage for SLL/ROL when the single-cycle barrel path is not used.

---
 rtl/sll_seq.sv | 103 ++++++++++
 tb/tb_sll_seq.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/sll_seq.sv
// Multi-cycle left shift / rotate, up to 2 bits per cycle.
// Define SLL_SEQ_STEP4_EN to allow steps of up to 4 bits per cycle.
module sll_seq #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] in,
  input  logic [CNT_W-1:0] cnt,
  input  logic             mode,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] out
);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] data;
  logic [CNT_W-1:0] rem;
  logic             rot;

  logic [CNT_W-1:0] step;
  logic [CNT_W-1:0] rem_nxt;
  logic [WIDTH-1:0] fill;
  logic [WIDTH-1:0] nxt;

  always_comb begin
`ifdef SLL_SEQ_STEP4_EN
    // a 3-bit tail is taken in one step to keep ceil(cnt/4) latency
    step = (rem >= CNT_W'(4)) ? CNT_W'(4) : rem;
`else
    step = (rem >= CNT_W'(2)) ? CNT_W'(2) : rem;
`endif
    rem_nxt = rem - step;
    fill    = '0;
    case (step)
      CNT_W'(1): fill = WIDTH'(data[WIDTH-1]);
      CNT_W'(2): fill = WIDTH'(data[WIDTH-1 -: 2]);
      CNT_W'(3): fill = WIDTH'(data[WIDTH-1 -: 3]);
      CNT_W'(4): fill = WIDTH'(data[WIDTH-1 -: 4]);
      default:   fill = '0;
    endcase
    nxt = (data << step) | (rot ? fill : '0);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      data  <= '0;
      rem   <= '0;
      rot   <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
      out   <= '0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            data <= in;
            rem  <= cnt;
            rot  <= mode;
            busy <= 1'b1;
            if (cnt == '0) begin
              state <= DONE;
              done  <= 1'b1;
              out   <= in;
            end else begin
              state <= SHIFT;
            end
          end
        end
        SHIFT: begin
          data <= nxt;
          rem  <= rem_nxt;
          if (rem_nxt == '0) begin
            state <= DONE;
            done  <= 1'b1;
            out   <= nxt;
          end
        end
        DONE: begin
          state <= IDLE;
          done  <= 1'b0;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          done  <= 1'b0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sll_seq.sv
// Self-checking bench for sll_seq: directed vectors plus
// randomized operations against a behavioural shift/rotate model.
module tb_sll_seq;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [15:0] in;
  logic [3:0]  cnt;
  logic        mode;
  logic        busy;
  logic        done;
  logic [15:0] out;

  int npass;
  int ntot;
  logic [15:0] last_out;

  sll_seq dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .in    (in),
    .cnt   (cnt),
    .mode  (mode),
    .busy  (busy),
    .done  (done),
    .out   (out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] model(input logic [15:0] a,
                                        input logic [3:0] c,
                                        input logic m);
    logic [31:0] w;
    logic [15:0] s;
    w = {a, a} << c;
    s = a << c;
    return m ? w[31:16] : s;
  endfunction

  function automatic int lat(input logic [3:0] c);
`ifdef SLL_SEQ_STEP4_EN
    return (int'(c) + 3) / 4;
`else
    return (int'(c) + 1) / 2;
`endif
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    ntot++;
    assert (obs === exp) npass++;
    else $error("FAIL %s: got %0h want %0h", tag, obs, exp);
  endtask

  // poke = cycle Ti in which a new start is driven while busy (0: none)
  task automatic op(input logic [15:0] a, input logic [3:0] c,
                    input logic m, input int poke,
                    input logic [15:0] exp);
    int k;
    int dcyc;
    int ndone;
    k = lat(c);
    dcyc = -1;
    ndone = 0;
    @(negedge clk);
    start = 1'b1;
    in = a;
    cnt = c;
    mode = m;
    @(negedge clk);
    for (int i = 1; i <= k + 6; i++) begin
      if (done) begin
        ndone++;
        dcyc = i;
        chk("out_at_done", 32'(out), 32'(exp));
      end else if (i <= k + 1) begin
        chk("out_held", 32'(out), 32'(last_out));
      end
      chk("busy", 32'(busy), 32'(i <= k + 1));
      in = 16'($urandom);
      cnt = 4'($urandom);
      mode = 1'($urandom);
      if (i == poke) begin
        start = 1'b1;
        in = ~a;
        cnt = 4'd1;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
    end
    chk("done_cycle", 32'(dcyc), 32'(k + 1));
    chk("done_count", 32'(ndone), 32'd1);
    last_out = exp;
  endtask

  initial begin
    int nd;
    int k;
    int pk;
    logic [15:0] a;
    logic [3:0] c;
    logic m;
    npass = 0;
    ntot = 0;
    rst_n = 1'b0;
    start = 1'b0;
    in = '0;
    cnt = '0;
    mode = 1'b0;
    last_out = '0;

    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_out", 32'(out), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_done", 32'(done), 32'h0);

    op(16'h00F1, 4'd5, 1'b0, 0, 16'h1E20);
    op(16'h8001, 4'd1, 1'b1, 0, 16'h0003);
    op(16'h1234, 4'd4, 1'b1, 0, 16'h2341);
    op(16'hABCD, 4'd0, 1'b0, 0, 16'hABCD);
    op(16'hFFFF, 4'd15, 1'b0, 0, 16'h8000);
    op(16'hFFFF, 4'd15, 1'b1, 0, 16'hFFFF);
    op(16'h0001, 4'd8, 1'b0, 2, 16'h0100);
    op(16'h0001, 4'd8, 1'b0, lat(4'd8) + 1, 16'h0100);

    // reset in the middle of a long operation
    @(negedge clk);
    start = 1'b1;
    in = 16'h0001;
    cnt = 4'd15;
    mode = 1'b0;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("mid_rst_out", 32'(out), 32'h0);
    chk("mid_rst_busy", 32'(busy), 32'h0);
    chk("mid_rst_done", 32'(done), 32'h0);
    rst_n = 1'b1;
    nd = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done) nd++;
    end
    chk("mid_rst_no_done", 32'(nd), 32'h0);
    last_out = '0;
    op(16'h0F0F, 4'd3, 1'b1, 0, 16'h7878);

    for (int t = 0; t < 40; t++) begin
      a = 16'($urandom);
      c = 4'($urandom);
      m = 1'($urandom);
      k = lat(c);
      pk = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, k + 1)) : 0;
      op(a, c, m, pk, model(a, c, m));
    end

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
